// File: rtl/write_back_stage.sv
// rtl/write_back_stage.sv - MIPS WB stage: MEM/WB register, load extension, regfile write port, halt FSM.
// Optional retire counter enabled by `define WB_RETIRE_COUNT_EN.
module write_back_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_regwrite,
    input  logic               i_memtoreg,
    input  logic [2:0]         i_load_type,
    input  logic [NB_DATA-1:0] i_mem_data,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic [NB_REG-1:0]  i_rd_addr,
    input  logic               i_halt,
    output logic               o_regwrite,
    output logic [NB_REG-1:0]  o_write_addr,
    output logic [NB_DATA-1:0] o_write_data,
    output logic               o_halted,
    output logic [31:0]        o_retired
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t state_q, state_d;

    logic               valid_q, regwrite_q, memtoreg_q, halt_q, fresh_q;
    logic [2:0]         load_type_q;
    logic [NB_DATA-1:0] mem_data_q, alu_result_q;
    logic [NB_REG-1:0]  rd_addr_q;

    logic               regwrite_q_out;
    logic [NB_REG-1:0]  write_addr_q;
    logic [NB_DATA-1:0] write_data_q;

    logic               regwrite_d;
    logic [NB_DATA-1:0] write_data_d;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;

    // fresh_q marks the first cycle an instruction sits in WB, so a stalled one retires once
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            halt_q       <= 1'b0;
            fresh_q      <= 1'b0;
            load_type_q  <= 3'd0;
            mem_data_q   <= '0;
            alu_result_q <= '0;
            rd_addr_q    <= '0;
        end else if (i_flush) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            halt_q     <= 1'b0;
            fresh_q    <= 1'b0;
        end else if (i_stall) begin
            fresh_q <= 1'b0;
        end else begin
            valid_q      <= i_valid;
            regwrite_q   <= i_regwrite;
            memtoreg_q   <= i_memtoreg;
            halt_q       <= i_halt;
            fresh_q      <= i_valid;
            load_type_q  <= i_load_type;
            mem_data_q   <= i_mem_data;
            alu_result_q <= i_alu_result;
            rd_addr_q    <= i_rd_addr;
        end
    end

    always_comb begin
        byte_sel = mem_data_q[7:0];
        case (alu_result_q[1:0])
            2'd1:    byte_sel = mem_data_q[15:8];
            2'd2:    byte_sel = mem_data_q[23:16];
            2'd3:    byte_sel = mem_data_q[31:24];
            default: byte_sel = mem_data_q[7:0];
        endcase
        half_sel = alu_result_q[1] ? mem_data_q[31:16] : mem_data_q[15:0];

        write_data_d = alu_result_q;
        if (memtoreg_q) begin
            case (load_type_q)
                3'b001:  write_data_d = {{24{byte_sel[7]}}, byte_sel};
                3'b010:  write_data_d = {{16{half_sel[15]}}, half_sel};
                3'b011:  write_data_d = {24'd0, byte_sel};
                3'b100:  write_data_d = {16'd0, half_sel};
                default: write_data_d = mem_data_q;
            endcase
        end
    end

    assign regwrite_d = valid_q & regwrite_q & ~halt_q & (rd_addr_q != '0) & (state_q == RUN);

    always_comb begin
        state_d = state_q;
        if (state_q == RUN && valid_q && halt_q) begin
            state_d = HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            regwrite_q_out <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
        end else begin
            state_q        <= state_d;
            regwrite_q_out <= regwrite_d;
            write_addr_q   <= rd_addr_q;
            write_data_q   <= write_data_d;
        end
    end

    assign o_regwrite   = regwrite_q_out;
    assign o_write_addr = write_addr_q;
    assign o_write_data = write_data_q;
    assign o_halted     = (state_q == HALTED);

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retired_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else if (state_q == RUN && valid_q && !halt_q && fresh_q) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign o_retired = retired_q;
`else
    assign o_retired = '0;
`endif

endmodule

// File: doc/write_back_stage.md
# write_back_stage

Final (WB) stage of the five-stage MIPS pipeline; the writer side of the register-file write port that the decode stage reads through its `i_regwrite` input. Latches MEM-stage results in a MEM/WB pipeline register and applies load sign/zero extension and byte/half lane selection. Drives the single register-file write port (enable, address, data) into instruction decode, and stops retirement when a HALT instruction reaches WB.

## Interface
Parameters:
- `NB_DATA`, 32, data/address width (only 32 is supported)
- `NB_REG`, 5, register address width

Ports:
- `clk` in 1: single clock; all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `i_valid` in 1: MEM stage holds a real instruction (0 = bubble)
- `i_stall` in 1: hold the WB register contents
- `i_flush` in 1: load a bubble
- `i_regwrite` in 1: instruction writes a register
- `i_memtoreg` in 1: write data comes from memory (1) or from the ALU/link result (0)
- `i_load_type` in 3: 000 LW, 001 LB, 010 LH, 011 LBU, 100 LHU; 101–111 treated as LW
- `i_mem_data` in 32: data-memory read word
- `i_alu_result` in 32: ALU result, link address for JAL/JALR, or load address
- `i_rd_addr` in 5: destination register
- `i_halt` in 1: instruction is HALT
- `o_regwrite` out 1: register-file write enable to instruction decode
- `o_write_addr` out 5: register-file write address
- `o_write_data` out 32: register-file write data
- `o_halted` out 1: processor halted
- `o_retired` out 32: retired-instruction count; present only with the macro, otherwise tied to 0

## Operation
- **MEM/WB register priority:** rst > i_flush > i_stall > load.
  - Flush loads a bubble: valid=0, regwrite=0, halt=0.
  - Stall holds the register.
- **Write data (combinational from the WB register, registered into the outputs):**
  - memtoreg=0: ALU result.
  - memtoreg=1: select by `i_load_type` using addr = alu_result[1:0]. Little-endian lanes: byte lane n = bits [8n+7:8n]; half lane = addr[1] (addr[0] ignored).
  - LB/LH: sign-extend the selected lane.
  - LBU/LHU: zero-extend the selected lane.
  - LW: whole word; addr ignored.
- **Write enable:** o_regwrite = valid & regwrite & !halt & (addr != 0) & state==RUN. A write to $0 is suppressed entirely; o_write_addr/o_write_data still show the latched values.
- **State machine:**
  - RUN → HALTED when a valid halt instruction sits in the WB register.
  - HALTED is left only by rst.
  - In HALTED: o_regwrite=0, o_halted=1, and new inputs are still latched but ignored.
- **Retire counter:** counts valid, non-halt instructions present in the WB register while in RUN. It counts once per instruction: a stalled instruction held over several cycles is counted once. It wraps 0xFFFFFFFF → 0.

## Timing
- Reset values: o_regwrite=0, o_write_addr=0, o_write_data=0, o_halted=0, o_retired=0, state=RUN, WB register = bubble.
- Latency is 2 rising edges: inputs are sampled at edge N into the MEM/WB register, and the output registers update at edge N+1. The register file consumes the outputs at edge N+2 (instruction decode's write-before-read is its own concern).
- o_halted rises 2 edges after the HALT is sampled; writes from instructions ahead of HALT complete normally.
- Stall with flush in the same cycle: the flush wins.
- rst during HALTED or mid-stall returns to RUN with all outputs zero on the next edge.
- During a stall the outputs repeat the held instruction's write. Re-writing the same value is harmless and is the required behaviour.

## Configuration
- **`WB_RETIRE_COUNT_EN` defined:** the 32-bit retire counter is implemented and drives `o_retired` as specified.
- **`WB_RETIRE_COUNT_EN` undefined:** no counter flops; `o_retired` is constant 0. All other behaviour is identical.

## Test plan
- **Reset:** rst high 2 cycles, random inputs → all outputs 0, o_halted=0.
- **ALU write:** ADD result 0x0000_1234 to r5, memtoreg=0 → o_regwrite=1, addr=5, data=0x0000_1234 two edges after sampling. Same instruction to r0 → o_regwrite=0.
- **Loads:** mem_data=0x80FF_7F81 with addr=1 and addr=2:
  - LB addr=1 → 0x0000_007F
  - LBU addr=0 → 0x0000_0081
  - LB addr=0 → 0xFFFF_FF81
  - LH addr=2 → 0xFFFF_80FF
  - LHU addr=2 → 0x0000_80FF
  - LW → 0x80FF_7F81
- **Stall/flush:**
  - Stall 3 cycles → the same write is held for 3 cycles.
  - Stall+flush together → o_regwrite=0 next cycle.
  - With the macro, o_retired increments by 1 only.
- **Halt:** write r3, then HALT, then write r4 → r3 is written, o_halted=1, r4 is never written. Then rst → state is RUN.
- **Counter wrap** (macro defined): preset near wrap via 0xFFFF_FFFE retirements (forced) plus 3 more → o_retired=1.
